// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier pipeline: digit
// encoding and the 3-bit multiplier-window recode function.
package booth_pkg;

  // Each Booth digit retires this many multiplier bits.
  localparam int BOOTH_RADIX_BITS = 2;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_POS1 = 3'd1,
    BD_POS2 = 3'd2,
    BD_NEG1 = 3'd3,
    BD_NEG2 = 3'd4
  } booth_digit_e;

  // Window is {b[2i+1], b[2i], b[2i-1]}; the bit below b[0] is an implicit 0.
  function automatic booth_digit_e booth_recode(input logic [2:0] bits);
    booth_digit_e d;
    d = BD_ZERO;
    case (bits)
      3'b000, 3'b111: d = BD_ZERO;
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mult_pipe_stage.sv
// One Booth digit step: recode the low multiplier window, add digit*a to
// the partial product, then arithmetic-shift {partial, multiplier} right by 2.
// Module name booth_stage; the file sits beside the top it serves.
module booth_stage
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    vld_in,
  input  logic                    smode_in,
  input  logic [WIDTH-1:0]        a_in,
  input  logic signed [WIDTH+3:0] acc_in,
  input  logic [WIDTH+1:0]        mq_in,
  input  logic                    prev_in,
  output logic                    vld_out,
  output logic                    smode_out,
  output logic [WIDTH-1:0]        a_out,
  output logic signed [WIDTH+3:0] acc_out,
  output logic [WIDTH+1:0]        mq_out,
  output logic                    prev_out
);

  // EW: extended operand width. AW: partial-product width with headroom for
  // acc + 2*a without overflow.
  localparam int EW = WIDTH + 2;
  localparam int AW = EW + 2;

  booth_digit_e         digit;
  logic signed [AW-1:0] a_x;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] sum;

  // Recode the window, form digit*a (negatives as full-width two's complement) and accumulate
  always_comb begin
    digit = booth_recode({mq_in[1:0], prev_in});
    a_x   = {{(AW-WIDTH){smode_in & a_in[WIDTH-1]}}, a_in};
    term  = '0;
    case (digit)
      BD_ZERO: term = '0;
      BD_POS1: term = a_x;
      BD_POS2: term = a_x <<< 1;
      BD_NEG1: term = -a_x;
      BD_NEG2: term = -(a_x <<< 1);
      default: term = '0;
    endcase
    sum = acc_in + term;
  end

  // Stage valid bit: cleared asynchronously, holds while the pipe is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_out <= 1'b0;
    end else if (en) begin
      vld_out <= vld_in;
    end
  end

  // Stage data: shifted partial product, remaining multiplier and carried operand
  always_ff @(posedge clk) begin
    if (en) begin
      smode_out <= smode_in;
      a_out     <= a_in;
      acc_out   <= sum >>> 2;
      mq_out    <= {sum[1:0], mq_in[EW-1:2]};
      prev_out  <= mq_in[1];
    end
  end

endmodule

// File: rtl/booth_mult_pipe.sv
// Pipelined radix-4 Booth multiplier, signed or unsigned per operation.
// Operand capture stage, one stage per Booth digit, then an output register.
// The whole pipe advances together; a stalled output freezes every stage.
module booth_mult_pipe
  import booth_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PROD_W = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              signed_mode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  localparam int D  = WIDTH / BOOTH_RADIX_BITS + 1;
  localparam int EW = WIDTH + 2;
  localparam int AW = EW + 2;

  logic advance;

  logic             vld_p0;
  logic             smode_p0;
  logic [WIDTH-1:0] a_p0;
  logic [EW-1:0]    b_p0;

  // Index 0 is the operand capture stage; index k is the output of digit stage k.
  logic [D:0]           vld_p;
  logic                 smode_p [D+1];
  logic [WIDTH-1:0]     a_p     [D+1];
  logic signed [AW-1:0] acc_p   [D+1];
  logic [EW-1:0]        mq_p    [D+1];
  logic                 prev_p  [D+1];

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  assign busy     = (|vld_p) | out_valid;

  // Operand capture valid: a bubble enters as invalid on any advancing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= in_valid;
    end
  end

  // Operand capture data: multiplier extended here, multiplicand extended per stage
  always_ff @(posedge clk) begin
    if (advance) begin
      smode_p0 <= signed_mode;
      a_p0     <= a;
      b_p0     <= {{2{signed_mode & b[WIDTH-1]}}, b};
    end
  end

  assign vld_p[0]   = vld_p0;
  assign smode_p[0] = smode_p0;
  assign a_p[0]     = a_p0;
  assign acc_p[0]   = '0;
  assign mq_p[0]    = b_p0;
  assign prev_p[0]  = 1'b0;

  for (genvar k = 1; k <= D; k++) begin : g_stage
    booth_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .vld_in    (vld_p[k-1]),
      .smode_in  (smode_p[k-1]),
      .a_in      (a_p[k-1]),
      .acc_in    (acc_p[k-1]),
      .mq_in     (mq_p[k-1]),
      .prev_in   (prev_p[k-1]),
      .vld_out   (vld_p[k]),
      .smode_out (smode_p[k]),
      .a_out     (a_p[k]),
      .acc_out   (acc_p[k]),
      .mq_out    (mq_p[k]),
      .prev_out  (prev_p[k])
    );
  end

  // Output register: low PROD_W bits of {partial, shifted-in product bits}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
    end else if (advance) begin
      out_valid <= vld_p[D];
      if (vld_p[D]) begin
        product <= {acc_p[D][PROD_W-EW-1:0], mq_p[D]};
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_pipe.sv
// Self-checking bench for booth_mult_pipe at WIDTH=8 and WIDTH=32.
module tb_booth_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, smode8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        in_valid32, in_ready32, smode32, out_valid32, out_ready32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] prod32;

  int checks = 0;
  int errors = 0;

  booth_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .signed_mode(smode8), .a(a8), .b(b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .product(prod8), .busy(busy8)
  );

  booth_mult_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .signed_mode(smode32), .a(a32), .b(b32), .out_valid(out_valid32),
    .out_ready(out_ready32), .product(prod32), .busy(busy32)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] sx, sy;
    sx = s ? {{8{x[7]}}, x} : {8'h00, x};
    sy = s ? {{8{y[7]}}, y} : {8'h00, y};
    return 16'(sx * sy);
  endfunction

  function automatic logic [63:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    sx = s ? {{32{x[31]}}, x} : {32'h0, x};
    sy = s ? {{32{y[31]}}, y} : {32'h0, y};
    return sx * sy;
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive8(input logic v, input logic [7:0] x, input logic [7:0] y, input logic s);
    in_valid8 = v;
    a8        = x;
    b8        = y;
    smode8    = s;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid8"}, 64'(out_valid8), 64'd0);
    check({tag, "_busy8"},      64'(busy8),      64'd0);
    check({tag, "_in_ready8"},  64'(in_ready8),  64'd1);
    check({tag, "_prod8"},      64'(prod8),      64'd0);
    check({tag, "_out_valid32"}, 64'(out_valid32), 64'd0);
    check({tag, "_busy32"},     64'(busy32),     64'd0);
    check({tag, "_prod32"},     prod32,          64'd0);
  endtask

  // Back-to-back table vectors: result j must appear 7+j negedges after the first drive.
  task automatic run_table();
    int got = 0;
    out_ready8 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid8) begin
        if (got < 8) begin
          check("tbl_prod", 64'(prod8), 64'(tbl[got].exp));
          check("tbl_cycle", 64'(c), 64'(7 + got));
        end else begin
          check("tbl_extra_valid", 64'(out_valid8), 64'd0);
        end
        got++;
      end
      if (c < 8) drive8(1'b1, tbl[c].a, tbl[c].b, tbl[c].s);
      else       drive8(1'b0, 8'h00, 8'h00, 1'b0);
    end
    check("tbl_count", 64'(got), 64'd8);
  endtask

  // Three ops in flight, output held for 4 cycles with junk offered on the input.
  task automatic run_stall();
    logic [7:0]  sa [3];
    logic [7:0]  sb [3];
    logic        ss [3];
    logic [15:0] se [3];
    int got = 0;
    sa[0] = 8'h03; sb[0] = 8'hFD; ss[0] = 1'b1;
    sa[1] = 8'h10; sb[1] = 8'h10; ss[1] = 1'b0;
    sa[2] = 8'h81; sb[2] = 8'h7F; ss[2] = 1'b1;
    for (int i = 0; i < 3; i++) se[i] = model8(sa[i], sb[i], ss[i]);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 3)                drive8(1'b1, sa[c], sb[c], ss[c]);
      else if (c >= 7 && c < 11) drive8(1'b1, 8'hA5, 8'h5A, 1'b1);
      else                      drive8(1'b0, 8'h00, 8'h00, 1'b0);
      out_ready8 = !(c >= 7 && c < 11);
      #1;
      if (c >= 7 && c < 11) begin
        check("stall_in_ready", 64'(in_ready8), 64'd0);
        check("stall_out_valid", 64'(out_valid8), 64'd1);
        check("stall_prod_held", 64'(prod8), 64'(se[0]));
      end
      if (out_valid8 && out_ready8) begin
        if (got < 3) begin
          check("stall_drain_prod", 64'(prod8), 64'(se[got]));
          check("stall_drain_cycle", 64'(c), 64'(11 + got));
        end else begin
          check("stall_extra_valid", 64'(out_valid8), 64'd0);
        end
        got++;
      end
    end
    check("stall_count", 64'(got), 64'd3);
    out_ready8 = 1'b1;
  endtask

  // Reset with results in flight, then a fresh op after release.
  task automatic run_reset();
    int seen = 0;
    out_ready8 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 3) drive8(1'b1, 8'h11 + 8'(c), 8'h22, 1'b0);
      else       drive8(1'b0, 8'h00, 8'h00, 1'b0);
    end
    out_ready8 = 1'b0;
    #1;
    check("prerst_out_valid", 64'(out_valid8), 64'd1);
    check("prerst_busy", 64'(busy8), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_state("rst_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready8 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid8) begin
        check("rst_new_cycle", 64'(c), 64'd15);
        check("rst_new_prod", 64'(prod8), 64'(model8(8'h05, 8'hF9, 1'b1)));
        seen++;
      end
      if (c == 8) drive8(1'b1, 8'h05, 8'hF9, 1'b1);
      else        drive8(1'b0, 8'h00, 8'h00, 1'b0);
    end
    check("rst_new_count", 64'(seen), 64'd1);
  endtask

  // Random operands, random bubbles and back-pressure on both widths at once.
  task automatic run_random(input int n);
    logic [15:0] q8  [$];
    logic [63:0] q32 [$];
    int sent8 = 0;
    int sent32 = 0;
    int cyc = 0;
    while ((sent8 < n || sent32 < n || q8.size() != 0 || q32.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready8  = ($urandom_range(0, 3) != 0);
      out_ready32 = ($urandom_range(0, 3) != 0);
      in_valid8   = (sent8 < n) && ($urandom_range(0, 4) != 0);
      in_valid32  = (sent32 < n) && ($urandom_range(0, 4) != 0);
      a8 = pick8();   b8 = pick8();   smode8 = 1'($urandom_range(0, 1));
      a32 = pick32(); b32 = pick32(); smode32 = 1'($urandom_range(0, 1));
      #1;
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) check("rnd8_unexpected_valid", 64'(out_valid8), 64'd0);
        else                check("rnd8_prod", 64'(prod8), 64'(q8.pop_front()));
      end
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) check("rnd32_unexpected_valid", 64'(out_valid32), 64'd0);
        else                 check("rnd32_prod", prod32, q32.pop_front());
      end
      if (in_valid8 && in_ready8) begin
        q8.push_back(model8(a8, b8, smode8));
        sent8++;
      end
      if (in_valid32 && in_ready32) begin
        q32.push_back(model32(a32, b32, smode32));
        sent32++;
      end
    end
    check("rnd_within_budget", 64'(cyc < 60000), 64'd1);
    check("rnd8_sent", 64'(sent8), 64'(n));
    check("rnd32_sent", 64'(sent32), 64'(n));
    check("rnd8_pending", 64'(q8.size()), 64'd0);
    check("rnd32_pending", 64'(q32.size()), 64'd0);
    @(negedge clk);
    in_valid8 = 1'b0; in_valid32 = 1'b0;
    out_ready8 = 1'b1; out_ready32 = 1'b1;
  endtask

  initial begin
    tbl[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    tbl[4] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    tbl[6] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[7] = '{8'h00, 8'hAB, 1'b1, 16'h0000};

    rst = 1'b0;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    out_ready8 = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; smode32 = 1'b0; out_ready32 = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_reset_state("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_table();
    run_stall();
    run_reset();
    run_random(10000);

    @(negedge clk);
    check("end_busy8", 64'(busy8), 64'd0);
    check("end_busy32", 64'(busy32), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_pipe.md
BOOTH_MULT_PIPE -- requirements
Module: booth_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; even, at least 4.
REQ-002 Parameter PROD_W, fixed at 2*WIDTH: product width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
REQ-008 a  input  WIDTH  multiplicand.
REQ-009 b  input  WIDTH  multiplier, recoded radix-4 Booth.
REQ-010 out_valid  output  1  product present.
REQ-011 out_ready  input  1  consumer accepts product this cycle.
REQ-012 product  output  PROD_W  a*b, interpreted per the operation's signed_mode.
REQ-013 busy  output  1  at least one operation in flight or held at output.

Function
REQ-014 The block SHALL extend both operands to WIDTH+2 bits internally: sign-extend when signed_mode=1, zero-extend when 0.
REQ-015 The block SHALL recode the extended b into D = WIDTH/2+1 Booth digits in {-2,-1,0,+1,+2}, using an implicit 0 below bit 0.
REQ-016 Each digit SHALL have exactly one pipeline stage. A stage adds digit*a to the partial product, then arithmetic-shifts the {partial, remaining b} pair right by 2.
REQ-017 A -a term SHALL be formed as the two's complement of the full extended width, not as a bitwise inversion alone.
REQ-018 A final output register SHALL present product = low PROD_W bits of the accumulated result.
REQ-019 Latency SHALL be D+1 cycles from an accepting edge (in_valid & in_ready) to out_valid, with no stalls. For WIDTH=32 this is 18 cycles.
REQ-020 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-021 Each stage SHALL carry a valid bit and the operation's signed_mode alongside its data.
REQ-022 Stall rule: advance = !out_valid | out_ready. When advance=0, all stages and the output register SHALL hold.
REQ-023 in_ready SHALL equal advance, so operands are never dropped while stalled.
REQ-024 A bubble (in_valid=0 on an advancing edge) SHALL enter stage 1 as invalid. Bubbles SHALL not generate out_valid.
REQ-025 product SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Operand changes while in_ready=0 SHALL have no effect.
REQ-027 busy SHALL be the OR of all stage valid bits and out_valid.
REQ-028 Simultaneous accept and output drain on the same edge SHALL both take effect.

Reset
REQ-029 On rst=1, all valid bits, out_valid and busy SHALL clear to 0 immediately, without waiting for a clock edge. product SHALL clear to 0.
REQ-030 During rst=1, in_ready SHALL read 1.
REQ-031 Reset mid-operation SHALL discard every in-flight operation. No stale product SHALL ever appear after reset release.
REQ-032 Datapath stage registers other than valid bits need no reset value.

Structure
REQ-033 A shared package booth_pkg SHALL hold the Booth digit encoding type and a recode function mapping 3 multiplier bits to a digit.
REQ-034 Sub-module booth_stage SHALL implement one digit step plus its registers, with WIDTH as a parameter. The top SHALL instantiate it D times via generate.

Verification
REQ-035 Bench scenarios at WIDTH=8 (D=5, latency 6):
- signed -128 x -128 (a=0x80, b=0x80, signed_mode=1) -> product 0x4000, out_valid exactly 6 cycles after accept.
- unsigned 255 x 255 (signed_mode=0) -> 0xFE01.
- signed 0xFF x 0x01 -> 0xFFFF; same operands unsigned -> 0x00FF. Issued back-to-back, results appear in order on consecutive cycles.
- out_ready=0 for 4 cycles with 3 operations in flight -> in_ready=0, product held; on release, all 3 results appear in order with none lost.
- rst pulse while 3 operations are in flight -> out_valid/busy drop immediately; after release, no output until a new accept, whose result arrives 6 cycles later.
- Random signed and unsigned stream of 10k operations at WIDTH=8 and WIDTH=32 -> every product matches the reference model.
